ucie_fdi_tx_flit_buffer: RTL and testbench
==========================================

Name: ucie_fdi_tx_flit_buffer

Overview:
- Parametrised transmit-side FDI buffer between the Protocol Layer and the Adapter transmit datapath.
- Accepts Protocol Layer data beats through the lp_irdy/lp_valid/pl_trdy handshake.
- Tracks flit boundaries and stores beats in a first-word-fall-through (FWFT) FIFO feeding a ready/valid downstream.
- Runs the FDI stall handshake (pl_stallreq/lp_stallack), so the Adapter can quiesce transmit traffic on a flit boundary before retrain or state change.

Parameters:
- NBYTES, 64, bytes per FDI transfer; data width is NBYTES*8.
- FLIT_BEATS, 4, transfers per flit; must be 1 or more.
- DEPTH, 16, FIFO depth in beats; power of 2, at least 2.

Ports:
- lclk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lp_irdy  in  1  Protocol Layer ready
- lp_valid  in  1  valid data from Protocol Layer
- lp_data  in  NBYTES*8  data from Protocol Layer
- lp_stallack  in  1  stall acknowledge from Protocol Layer
- pl_trdy  out  1  beat accepted this cycle when high with lp_irdy&lp_valid
- pl_stallreq  out  1  stall request to Protocol Layer
- stall_req_in  in  1  Adapter FSM requests transmit stall
- stall_done  out  1  stalled and FIFO fully drained
- tx_valid  out  1  head beat valid
- tx_data  out  NBYTES*8  head beat data
- tx_last  out  1  head beat is last beat of a flit
- tx_ready  in  1  downstream accepts head beat
- fifo_level  out  $clog2(DEPTH+1)  beats stored
- protocol_err  out  1  sticky: lp_stallack seen mid-flit

Behaviour:
- Reset (async, active-high), all registered outputs 0: pl_stallreq=0, protocol_err=0, fifo empty, fifo_level=0, beat counter=0, state=RUN. Combinational outputs follow: pl_trdy=0 (during reset), tx_valid=0, stall_done=0.
- Push: push = lp_irdy & lp_valid & pl_trdy. lp_valid without lp_irdy, or lp_irdy without lp_valid, is ignored; no write and no counter change.
- Beat counter: increments mod FLIT_BEATS per push. The stored entry carries last = (counter==FLIT_BEATS-1).
- pl_trdy = !full & (state==RUN | state==REQ). Combinational. No bypass at full: a simultaneous pop does not enable a push at full.
- FWFT FIFO: tx_valid = !empty; tx_data and tx_last come from the head entry; pop = tx_valid & tx_ready.
- Latency: a push into an empty FIFO gives tx_valid=1 on the next cycle.
- fifo_level updates every cycle: +1 on push only, -1 on pop only, unchanged on both.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from fifo_level.
- Stall FSM (registered, lclk):
  - RUN: stall_req_in=1 -> REQ; pl_stallreq=1 next cycle.
  - REQ: beats still accepted. On lp_stallack=1 -> STALLED. If the beat counter != 0 at that time (ack mid-flit), set protocol_err and still go to STALLED.
  - STALLED: pl_trdy=0. stall_done = empty. stall_req_in=0 -> UNSTALL, with pl_stallreq=0 next cycle.
  - UNSTALL: pl_trdy=0. lp_stallack=0 -> RUN.
  - stall_req_in deasserted while in REQ: stay in REQ until lp_stallack, then STALLED. Because stall_req_in is then 0, leave STALLED -> UNSTALL on the next cycle.
- A push and an lp_stallack in the same cycle: the push completes first. The counter value used for the mid-flit check is the value after that push.
- Downstream pops continue in every state; the FIFO always drains.
- Reset mid-operation: the FIFO is discarded, the FSM returns to RUN, and protocol_err is cleared.

Optional Feature:
- Macro: UCIE_FDI_LINKERROR_FLUSH_EN.
- When defined:
  - Adds input port lp_linkerror (1 bit).
  - When lp_linkerror=1 in a cycle: the FIFO empties next cycle, the beat counter clears, pl_stallreq clears, and the FSM goes to RUN. protocol_err is held.
  - Pushes and pops in that cycle are discarded. pl_trdy=0 while lp_linkerror=1.
- When undefined: the port is absent and no flush logic is present.

Test Plan (NBYTES=4, FLIT_BEATS=4, DEPTH=8):
- Push 4 beats 0x11..0x44 with tx_ready=1 -> tx_valid appears one cycle after the first push; beats appear in order; tx_last=1 only on 0x44; fifo_level stays at 0 or 1.
- tx_ready=0, push 10 beats -> pl_trdy drops after the 8th beat; fifo_level=8. Then tx_ready=1 -> 8 beats drain in order, and pl_trdy rises the cycle after the first pop.
- stall_req_in=1 after beat 4; lp_stallack 2 cycles after pl_stallreq -> STALLED; pl_trdy=0; stall_done=1 once fifo_level=0. Then drop stall_req_in -> pl_stallreq=0 next cycle. Drop lp_stallack -> pl_trdy=1.
- stall_req_in=1 after beat 2, lp_stallack=1 immediately -> protocol_err=1 (sticky); FSM reaches STALLED.
- Assert rst mid-flit with fifo_level=5 -> all outputs 0 asynchronously; after release, a new 4-beat flit has tx_last on its 4th beat.
- With UCIE_FDI_LINKERROR_FLUSH_EN, fifo_level=6, pulse lp_linkerror -> fifo_level=0 and tx_valid=0 next cycle; the next flit's tx_last falls on its 4th beat.

Source files
------------

// File: rtl/ucie_fdi_tx_flit_buffer.sv
// FDI transmit flit buffer: Protocol Layer beat intake, flit-boundary tracking, FWFT FIFO and stall handshake.
// Optional link-error flush is enabled by defining UCIE_FDI_LINKERROR_FLUSH_EN.
module ucie_fdi_tx_flit_buffer #(
  parameter int NBYTES     = 64,
  parameter int FLIT_BEATS = 4,
  parameter int DEPTH      = 16
) (
  input  logic                         lclk,
  input  logic                         rst,
  input  logic                         lp_irdy,
  input  logic                         lp_valid,
  input  logic [NBYTES*8-1:0]          lp_data,
  input  logic                         lp_stallack,
`ifdef UCIE_FDI_LINKERROR_FLUSH_EN
  input  logic                         lp_linkerror,
`endif
  output logic                         pl_trdy,
  output logic                         pl_stallreq,
  input  logic                         stall_req_in,
  output logic                         stall_done,
  output logic                         tx_valid,
  output logic [NBYTES*8-1:0]          tx_data,
  output logic                         tx_last,
  input  logic                         tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         protocol_err
);

  localparam int DW = NBYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (FLIT_BEATS > 1) ? $clog2(FLIT_BEATS) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_REQ,
    S_STALLED,
    S_UNSTALL
  } state_t;

  state_t          r_state;
  logic            r_stallreq;
  logic            r_perr;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [CW-1:0]   r_cnt;
  logic [DW:0]     r_mem [DEPTH];

  logic            w_flush;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_cnt_last;
  logic [CW-1:0]   w_cnt_nxt;
  logic [DW:0]     w_head;

`ifdef UCIE_FDI_LINKERROR_FLUSH_EN
  assign w_flush = lp_linkerror;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // Gated by rst so the Protocol Layer never sees a ready while the buffer is held in reset.
  assign pl_trdy = !rst && !w_flush && !w_full &&
                   ((r_state == S_RUN) || (r_state == S_REQ));

  assign w_push = lp_irdy & lp_valid & pl_trdy;
  assign w_pop  = tx_valid & tx_ready & !w_flush;

  assign w_cnt_last = (r_cnt == CW'(FLIT_BEATS - 1));
  assign w_cnt_nxt  = !w_push ? r_cnt : (w_cnt_last ? '0 : r_cnt + CW'(1));

  assign w_head       = r_mem[r_rptr];
  assign tx_valid     = !w_empty;
  assign tx_data      = w_head[DW-1:0];
  assign tx_last      = w_head[DW];
  assign fifo_level   = r_level;
  assign pl_stallreq  = r_stallreq;
  assign protocol_err = r_perr;
  assign stall_done   = (r_state == S_STALLED) && w_empty;

  always_ff @(posedge lclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_cnt_last, lp_data};
    end
  end

  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Mid-flit check uses the post-push counter so an ack arriving with the final beat is legal.
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_stallreq <= 1'b0;
      r_perr     <= 1'b0;
    end else if (w_flush) begin
      r_state    <= S_RUN;
      r_stallreq <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (stall_req_in) begin
            r_state    <= S_REQ;
            r_stallreq <= 1'b1;
          end
        end
        S_REQ: begin
          if (lp_stallack) begin
            r_state <= S_STALLED;
            if (w_cnt_nxt != '0) begin
              r_perr <= 1'b1;
            end
          end
        end
        S_STALLED: begin
          if (!stall_req_in) begin
            r_state    <= S_UNSTALL;
            r_stallreq <= 1'b0;
          end
        end
        S_UNSTALL: begin
          if (!lp_stallack) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_fdi_tx_flit_buffer.sv
// Self-checking bench for ucie_fdi_tx_flit_buffer (NBYTES=4, FLIT_BEATS=4, DEPTH=8).
// Link-error flush sequence runs only when UCIE_FDI_LINKERROR_FLUSH_EN is defined.
module tb_ucie_fdi_tx_flit_buffer;

  localparam int NB = 4;
  localparam int FB = 4;
  localparam int DP = 8;

  logic        lclk = 1'b0;
  logic        rst;
  logic        lp_irdy, lp_valid, lp_stallack, stall_req_in, tx_ready;
  logic [31:0] lp_data;
  logic        pl_trdy, pl_stallreq, stall_done, tx_valid, tx_last, protocol_err;
  logic [31:0] tx_data;
  logic [3:0]  fifo_level;
`ifdef UCIE_FDI_LINKERROR_FLUSH_EN
  logic        lp_linkerror = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 lclk = ~lclk;

  ucie_fdi_tx_flit_buffer #(.NBYTES(NB), .FLIT_BEATS(FB), .DEPTH(DP)) dut (
    .lclk(lclk), .rst(rst),
    .lp_irdy(lp_irdy), .lp_valid(lp_valid), .lp_data(lp_data),
    .lp_stallack(lp_stallack),
`ifdef UCIE_FDI_LINKERROR_FLUSH_EN
    .lp_linkerror(lp_linkerror),
`endif
    .pl_trdy(pl_trdy), .pl_stallreq(pl_stallreq),
    .stall_req_in(stall_req_in), .stall_done(stall_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .fifo_level(fifo_level), .protocol_err(protocol_err)
  );

  typedef struct packed {
    logic        irdy;
    logic        valid;
    logic [31:0] data;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [3:0]  exp_level;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lp_irdy = 1'b0; lp_valid = 1'b0; lp_data = '0; lp_stallack = 1'b0;
    stall_req_in = 1'b0; tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_beats(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      lp_irdy = 1'b1; lp_valid = 1'b1; lp_data = base + 32'(i);
      tick();
    end
    lp_irdy = 1'b0; lp_valid = 1'b0;
  endtask

  task automatic drain_expect(input int n, input logic [31:0] base, input int idx0);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(tx_valid), 32'd1);
      check("drain_data", tx_data, base + 32'(i));
      check("drain_last", 32'(tx_last), 32'(((idx0 + i) % FB) == FB - 1));
      tick();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(fifo_level), 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    logic [32:0] mq [$];
    int          mcnt;
    int          waited;
    logic        m_push, m_pop;

    vecs[0] = '{1'b1, 1'b0, 32'hAA, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 32'hBB, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0};
    vecs[2] = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b0, 4'd1};
    vecs[3] = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 4'd2};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1'b0, 4'd1};
    vecs[5] = '{1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b0, 4'd1};
    vecs[6] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h33, 1'b0, 4'd2};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b1, 4'd1};
    vecs[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 4'd0};

    rst = 1'b1;
    lp_irdy = 1'b0; lp_valid = 1'b0; lp_data = '0; lp_stallack = 1'b0;
    stall_req_in = 1'b0; tx_ready = 1'b0;
    #2;
    check("rst_trdy", 32'(pl_trdy), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_stallreq", 32'(pl_stallreq), 32'd0);
    check("rst_done", 32'(stall_done), 32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);
    do_reset();
    check("run_trdy", 32'(pl_trdy), 32'd1);

    // Handshake filtering and FWFT behaviour.
    for (int i = 0; i < 9; i++) begin
      lp_irdy = vecs[i].irdy; lp_valid = vecs[i].valid;
      lp_data = vecs[i].data; tx_ready = vecs[i].rdy;
      tick();
      check("vec_valid", 32'(tx_valid), 32'(vecs[i].exp_valid));
      check("vec_level", 32'(fifo_level), 32'(vecs[i].exp_level));
      if (vecs[i].exp_valid) begin
        check("vec_data", tx_data, vecs[i].exp_data);
        check("vec_last", 32'(tx_last), 32'(vecs[i].exp_last));
      end
    end
    lp_irdy = 1'b0; lp_valid = 1'b0; tx_ready = 1'b0;

    // Streaming flit with downstream always ready.
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lp_irdy = 1'b1; lp_valid = 1'b1; lp_data = 32'h11 * 32'(i + 1);
      tick();
      check("strm_valid", 32'(tx_valid), 32'd1);
      check("strm_data", tx_data, 32'h11 * 32'(i + 1));
      check("strm_last", 32'(tx_last), 32'(i == 3));
      check("strm_level", 32'(fifo_level), 32'd1);
    end
    lp_irdy = 1'b0; lp_valid = 1'b0;
    tick();
    check("strm_end_valid", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Fill to full, no bypass, then drain.
    for (int i = 0; i < 10; i++) begin
      lp_irdy = 1'b1; lp_valid = 1'b1; lp_data = 32'(i + 1);
      #1;
      check("fill_trdy", 32'(pl_trdy), 32'(i < DP));
      tick();
    end
    lp_irdy = 1'b0; lp_valid = 1'b0;
    check("fill_level", 32'(fifo_level), 32'd8);
    lp_irdy = 1'b1; lp_valid = 1'b1; lp_data = 32'hDEAD; tx_ready = 1'b1;
    #1;
    check("full_pop_no_bypass", 32'(pl_trdy), 32'd0);
    tick();
    lp_irdy = 1'b0; lp_valid = 1'b0;
    check("trdy_after_pop", 32'(pl_trdy), 32'd1);
    check("level_after_pop", 32'(fifo_level), 32'd7);
    drain_expect(7, 32'd2, 1);

    // Stall on a flit boundary with data still queued.
    push_beats(4, 32'h100);
    stall_req_in = 1'b1;
    tick();
    check("stl_req", 32'(pl_stallreq), 32'd1);
    check("stl_req_trdy", 32'(pl_trdy), 32'd1);
    tick();
    lp_stallack = 1'b1;
    tick();
    check("stl_trdy", 32'(pl_trdy), 32'd0);
    check("stl_done_busy", 32'(stall_done), 32'd0);
    check("stl_perr", 32'(protocol_err), 32'd0);
    tx_ready = 1'b1;
    waited = 0;
    while (fifo_level != 0 && waited < 20) begin
      tick();
      waited++;
    end
    check("stl_drain_timeout", 32'(waited < 20), 32'd1);
    check("stl_done", 32'(stall_done), 32'd1);
    tx_ready = 1'b0;
    stall_req_in = 1'b0;
    tick();
    check("unstl_req", 32'(pl_stallreq), 32'd0);
    check("unstl_trdy", 32'(pl_trdy), 32'd0);
    check("unstl_done", 32'(stall_done), 32'd0);
    lp_stallack = 1'b0;
    tick();
    check("resume_trdy", 32'(pl_trdy), 32'd1);

    // Ack together with the closing beat; stall_req_in withdrawn while in REQ.
    push_beats(3, 32'h200);
    stall_req_in = 1'b1;
    tick();
    stall_req_in = 1'b0;
    tick();
    check("req_hold", 32'(pl_stallreq), 32'd1);
    check("req_hold_trdy", 32'(pl_trdy), 32'd1);
    lp_irdy = 1'b1; lp_valid = 1'b1; lp_data = 32'h203; lp_stallack = 1'b1;
    tick();
    lp_irdy = 1'b0; lp_valid = 1'b0;
    check("ack_last_perr", 32'(protocol_err), 32'd0);
    check("ack_last_level", 32'(fifo_level), 32'd4);
    check("ack_last_trdy", 32'(pl_trdy), 32'd0);
    tick();
    check("auto_unstl_req", 32'(pl_stallreq), 32'd0);
    lp_stallack = 1'b0;
    tick();
    check("auto_run_trdy", 32'(pl_trdy), 32'd1);
    drain_expect(4, 32'h200, 0);

    // Mid-flit ack sets the sticky error.
    do_reset();
    push_beats(2, 32'h300);
    stall_req_in = 1'b1; lp_stallack = 1'b1;
    tick();
    tick();
    check("perr_set", 32'(protocol_err), 32'd1);
    check("perr_trdy", 32'(pl_trdy), 32'd0);
    check("perr_done", 32'(stall_done), 32'd0);
    stall_req_in = 1'b0;
    tick();
    lp_stallack = 1'b0;
    tick();
    check("perr_sticky", 32'(protocol_err), 32'd1);
    check("perr_run_trdy", 32'(pl_trdy), 32'd1);

    // Asynchronous reset mid-flit at level 5.
    push_beats(3, 32'h302);
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    rst = 1'b1;
    #1;
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_perr", 32'(protocol_err), 32'd0);
    check("arst_trdy", 32'(pl_trdy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    push_beats(4, 32'h400);
    drain_expect(4, 32'h400, 0);

`ifdef UCIE_FDI_LINKERROR_FLUSH_EN
    push_beats(6, 32'h500);
    check("le_pre_level", 32'(fifo_level), 32'd6);
    lp_linkerror = 1'b1; lp_irdy = 1'b1; lp_valid = 1'b1; tx_ready = 1'b1;
    #1;
    check("le_trdy", 32'(pl_trdy), 32'd0);
    tick();
    lp_linkerror = 1'b0; lp_irdy = 1'b0; lp_valid = 1'b0; tx_ready = 1'b0;
    check("le_level", 32'(fifo_level), 32'd0);
    check("le_valid", 32'(tx_valid), 32'd0);
    push_beats(4, 32'h600);
    drain_expect(4, 32'h600, 0);
`endif

    // Randomized datapath against a queue model.
    do_reset();
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      lp_irdy  = ($urandom % 4) != 0;
      lp_valid = ($urandom % 4) != 0;
      lp_data  = $urandom;
      tx_ready = ($urandom % 3) == 0;
      #1;
      check("rnd_trdy", 32'(pl_trdy), 32'(mq.size() < DP));
      m_push = lp_irdy && lp_valid && (mq.size() < DP);
      m_pop  = tx_ready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({mcnt == FB - 1, lp_data});
        mcnt = (mcnt + 1) % FB;
      end
      tick();
      check("rnd_level", 32'(fifo_level), 32'(mq.size()));
      check("rnd_valid", 32'(tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("rnd_data", tx_data, mq[0][31:0]);
        check("rnd_last", 32'(tx_last), 32'(mq[0][32]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
